cci_mpf_csr_mgr: RTL and testbench

- Parametrised MMIO CSR manager for MPF.
- Decodes CCI MMIO reads and writes that fall inside MPF's allocated window.
- Generates one device-feature-header (DFH) per shim region, forming a linked feature list.
- Forwards shim CSR writes, returns read responses through a fixed-latency pipeline, and owns the VTP mode register, including a self-clearing translation-cache invalidate.
- Sits between the AFU MMIO decode and the MPF shims.
- Generalises the fixed five-shim layout to N shims of configurable CSR count.

---
 rtl/cci_mpf_csr_mgr.sv | 152 +++++++++++++++
 tb/tb_cci_mpf_csr_mgr.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_csr_mgr.sv
// MMIO CSR manager for MPF: decodes MMIO reads and writes inside the MPF
// window, generates one DFH per shim region (a linked feature list),
// forwards shim CSR writes, returns reads with fixed latency 2 and owns the
// VTP mode register with its self-clearing translation-cache invalidate.
// Ports: clk, reset_n (sync, active low); mmio_wr_* / mmio_rd_* request side;
// rd_rsp_* response side; shim_wr_* write forwarding; shim_rd_data flattened
// shim readback; vtp_enabled / vtp_inval_pulse VTP mode outputs.
module cci_mpf_csr_mgr #(
  parameter int NUM_SHIMS          = 5,
  parameter int CSRS_PER_SHIM      = 8,
  parameter int MMIO_ADDR_WIDTH    = 16,
  parameter int DFH_MMIO_BASE_ADDR = 0,
  parameter int DFH_MMIO_NEXT_ADDR = 0
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   mmio_wr_valid,
  input  logic [MMIO_ADDR_WIDTH-1:0]             mmio_wr_addr,
  input  logic [63:0]                            mmio_wr_data,
  input  logic                                   mmio_rd_valid,
  input  logic [MMIO_ADDR_WIDTH-1:0]             mmio_rd_addr,
  input  logic [8:0]                             mmio_rd_tid,
  output logic                                   rd_rsp_valid,
  output logic [8:0]                             rd_rsp_tid,
  output logic [63:0]                            rd_rsp_data,
  output logic [NUM_SHIMS-1:0]                   shim_wr_valid,
  output logic [$clog2(CSRS_PER_SHIM)-1:0]       shim_wr_idx,
  output logic [63:0]                            shim_wr_data,
  input  logic [NUM_SHIMS*CSRS_PER_SHIM*64-1:0]  shim_rd_data,
  output logic                                   vtp_enabled,
  output logic                                   vtp_inval_pulse
);

  localparam int IDX_W  = $clog2(CSRS_PER_SHIM);
  localparam int SHIM_W = (NUM_SHIMS > 1) ? $clog2(NUM_SHIMS) : 1;
  localparam int WIN    = 2 * NUM_SHIMS * CSRS_PER_SHIM;
  localparam logic [MMIO_ADDR_WIDTH-1:0] BASE_A = MMIO_ADDR_WIDTH'(DFH_MMIO_BASE_ADDR);
  localparam logic [MMIO_ADDR_WIDTH-1:0] WIN_A  = MMIO_ADDR_WIDTH'(WIN);

  // DFH for shim i; next-offset and id arithmetic truncated to field width.
  function automatic logic [63:0] dfh_word(input logic [SHIM_W-1:0] shim);
    logic [23:0] nxt;
    logic        eol;
    if (int'(shim) < NUM_SHIMS - 1) begin
      nxt = 24'(CSRS_PER_SHIM * 8);
      eol = 1'b0;
    end else if (DFH_MMIO_NEXT_ADDR == 0) begin
      nxt = '0;
      eol = 1'b1;
    end else begin
      nxt = 24'(DFH_MMIO_NEXT_ADDR -
                (DFH_MMIO_BASE_ADDR + int'(shim) * 2 * CSRS_PER_SHIM) * 4);
      eol = 1'b0;
    end
    return {4'h2, 19'b0, eol, nxt, 4'b0, 12'(int'(shim) + 1)};
  endfunction

  // ---------------- write decode ----------------
  logic [MMIO_ADDR_WIDTH-1:0] w_wr_off;
  logic                       w_wr_hit;
  logic [SHIM_W-1:0]          w_wr_shim;
  logic [IDX_W-1:0]           w_wr_idx;
  logic                       w_wr_fwd;
  logic                       w_wr_vtp;
  logic [NUM_SHIMS-1:0]       w_wr_onehot;

  assign w_wr_off    = mmio_wr_addr - BASE_A;
  assign w_wr_hit    = (mmio_wr_addr >= BASE_A) && (w_wr_off < WIN_A);
  assign w_wr_shim   = SHIM_W'(w_wr_off >> (IDX_W + 1));
  assign w_wr_idx    = w_wr_off[IDX_W:1];
  assign w_wr_fwd    = mmio_wr_valid && w_wr_hit && !w_wr_off[0] && (w_wr_idx != '0);
  assign w_wr_vtp    = (w_wr_shim == '0) && (w_wr_idx == IDX_W'(1));
  assign w_wr_onehot = NUM_SHIMS'(1) << w_wr_shim;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shim_wr_valid   <= '0;
      shim_wr_idx     <= '0;
      shim_wr_data    <= '0;
      vtp_enabled     <= 1'b0;
      vtp_inval_pulse <= 1'b0;
    end else begin
      shim_wr_valid   <= '0;
      vtp_inval_pulse <= 1'b0;
      if (w_wr_fwd) begin
        shim_wr_valid <= w_wr_onehot;
        shim_wr_idx   <= w_wr_idx;
        shim_wr_data  <= mmio_wr_data;
        if (w_wr_vtp) begin
          vtp_enabled     <= mmio_wr_data[0];
          vtp_inval_pulse <= mmio_wr_data[1];
        end
      end
    end
  end

  // ---------------- read pipeline ----------------
  logic [MMIO_ADDR_WIDTH-1:0] w_rd_off;
  logic                       w_rd_acc;
  logic                       r_s1_valid;
  logic [MMIO_ADDR_WIDTH-1:0] r_s1_off;
  logic [8:0]                 r_s1_tid;
  logic                       r_s1_vtp;
  logic [SHIM_W-1:0]          w_s1_shim;
  logic [IDX_W-1:0]           w_s1_idx;
  logic [63:0]                w_s1_data;

  assign w_rd_off  = mmio_rd_addr - BASE_A;
  assign w_rd_acc  = mmio_rd_valid && (mmio_rd_addr >= BASE_A) && (w_rd_off < WIN_A);
  assign w_s1_shim = SHIM_W'(r_s1_off >> (IDX_W + 1));
  assign w_s1_idx  = r_s1_off[IDX_W:1];

  always_comb begin
    w_s1_data = '0;
    if (!r_s1_off[0]) begin
      if (w_s1_idx == '0) begin
        w_s1_data = dfh_word(w_s1_shim);
      end else if ((w_s1_shim == '0) && (w_s1_idx == IDX_W'(1))) begin
        w_s1_data = {62'b0, 1'b0, r_s1_vtp};
      end else begin
        w_s1_data = shim_rd_data[(int'(w_s1_shim) * CSRS_PER_SHIM + int'(w_s1_idx)) * 64 +: 64];
      end
    end
  end

  // VTP state is captured at acceptance so a same-cycle write is not visible
  // to the read (read returns the pre-write value).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_off     <= '0;
      r_s1_tid     <= '0;
      r_s1_vtp     <= 1'b0;
      rd_rsp_valid <= 1'b0;
      rd_rsp_tid   <= '0;
      rd_rsp_data  <= '0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_s1_off <= w_rd_off;
        r_s1_tid <= mmio_rd_tid;
        r_s1_vtp <= vtp_enabled;
      end
      rd_rsp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        rd_rsp_tid  <= r_s1_tid;
        rd_rsp_data <= w_s1_data;
      end
    end
  end

endmodule

// File: tb/tb_cci_mpf_csr_mgr.sv
module tb_cci_mpf_csr_mgr;

  localparam int NS   = 5;
  localparam int CPS  = 8;
  localparam int AW   = 16;
  localparam int BASE = 'h100;
  localparam int NEXT = 0;
  localparam int WIN  = 2 * NS * CPS;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    mmio_wr_valid;
  logic [AW-1:0]           mmio_wr_addr;
  logic [63:0]             mmio_wr_data;
  logic                    mmio_rd_valid;
  logic [AW-1:0]           mmio_rd_addr;
  logic [8:0]              mmio_rd_tid;
  logic                    rd_rsp_valid;
  logic [8:0]              rd_rsp_tid;
  logic [63:0]             rd_rsp_data;
  logic [NS-1:0]           shim_wr_valid;
  logic [2:0]              shim_wr_idx;
  logic [63:0]             shim_wr_data;
  logic [NS*CPS*64-1:0]    shim_rd_data;
  logic                    vtp_enabled;
  logic                    vtp_inval_pulse;

  logic [63:0] pat [NS*CPS];

  always #5 clk = ~clk;

  always_comb begin
    shim_rd_data = '0;
    for (int s = 0; s < NS * CPS; s++) shim_rd_data[s*64 +: 64] = pat[s];
  end

  cci_mpf_csr_mgr #(
    .NUM_SHIMS          (NS),
    .CSRS_PER_SHIM      (CPS),
    .MMIO_ADDR_WIDTH    (AW),
    .DFH_MMIO_BASE_ADDR (BASE),
    .DFH_MMIO_NEXT_ADDR (NEXT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mmio_wr_valid   (mmio_wr_valid),
    .mmio_wr_addr    (mmio_wr_addr),
    .mmio_wr_data    (mmio_wr_data),
    .mmio_rd_valid   (mmio_rd_valid),
    .mmio_rd_addr    (mmio_rd_addr),
    .mmio_rd_tid     (mmio_rd_tid),
    .rd_rsp_valid    (rd_rsp_valid),
    .rd_rsp_tid      (rd_rsp_tid),
    .rd_rsp_data     (rd_rsp_data),
    .shim_wr_valid   (shim_wr_valid),
    .shim_wr_idx     (shim_wr_idx),
    .shim_wr_data    (shim_wr_data),
    .shim_rd_data    (shim_rd_data),
    .vtp_enabled     (vtp_enabled),
    .vtp_inval_pulse (vtp_inval_pulse)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  typedef struct {
    int unsigned due;
    logic [8:0]  tid;
    logic [63:0] data;
  } rsp_t;
  rsp_t rq[$];
  logic m_vtp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mk_pat(input int unsigned s);
    return {16'hC0DE, 8'(s), 8'hA5, 32'(s * 32'h1001 + 32'h5A00_0000)};
  endfunction

  // DFH from the feature-list rules, plain arithmetic.
  function automatic logic [63:0] ref_dfh(input int unsigned i);
    longint unsigned nxt, eol;
    if (i < NS - 1) begin
      nxt = 64'(CPS * 8);
      eol = 0;
    end else if (NEXT == 0) begin
      nxt = 0;
      eol = 1;
    end else begin
      nxt = 64'(NEXT - (BASE + int'(i) * 2 * CPS) * 4) & 64'hFF_FFFF;
      eol = 0;
    end
    return (64'h2 << 60) | (eol << 40) | (nxt << 16) | (64'(i + 1) & 64'hFFF);
  endfunction

  function automatic bit ref_read(input int unsigned a, input logic vtp, output logic [63:0] d);
    int unsigned off, sh, ix;
    d = '0;
    if (a < BASE || a >= BASE + WIN) return 1'b0;
    off = a - BASE;
    if (off % 2 == 1) return 1'b1;
    sh = off / (2 * CPS);
    ix = (off / 2) % CPS;
    if (ix == 0) d = ref_dfh(sh);
    else if (sh == 0 && ix == 1) d = {63'b0, vtp};
    else d = pat[sh * CPS + ix];
    return 1'b1;
  endfunction

  // One clock: drive inputs, predict, advance, compare every output.
  task automatic step(input bit rv, input int unsigned ra, input logic [8:0] rt,
                      input bit wv, input int unsigned wa, input logic [63:0] wd);
    logic [63:0] d;
    logic [NS-1:0] e_wv;
    logic [2:0] e_idx;
    logic [63:0] e_wd;
    logic e_pulse;
    bit e_rv;
    int unsigned off;
    e_wv = '0; e_idx = '0; e_wd = '0; e_pulse = 1'b0;
    mmio_rd_valid = rv; mmio_rd_addr = AW'(ra); mmio_rd_tid = rt;
    mmio_wr_valid = wv; mmio_wr_addr = AW'(wa); mmio_wr_data = wd;
    if (!reset_n) begin
      rq.delete();
      m_vtp = 1'b0;
    end else begin
      if (rv && ref_read(ra, m_vtp, d)) rq.push_back('{cyc + 1, rt, d});
      if (wv && wa >= BASE && wa < BASE + WIN && (wa - BASE) % 2 == 0 &&
          ((wa - BASE) / 2) % CPS != 0) begin
        off   = wa - BASE;
        e_wv  = NS'(1) << (off / (2 * CPS));
        e_idx = 3'((off / 2) % CPS);
        e_wd  = wd;
        if (off == 2) begin
          m_vtp   = wd[0];
          e_pulse = wd[1];
        end
      end
    end
    @(posedge clk);
    #1;
    check("shim_wr_valid", 64'(shim_wr_valid), 64'(e_wv));
    if (e_wv != '0) begin
      check("shim_wr_idx", 64'(shim_wr_idx), 64'(e_idx));
      check("shim_wr_data", shim_wr_data, e_wd);
    end
    check("vtp_enabled", 64'(vtp_enabled), 64'(m_vtp));
    check("vtp_inval_pulse", 64'(vtp_inval_pulse), 64'(e_pulse));
    e_rv = (rq.size() > 0) && (rq[0].due == cyc);
    check("rd_rsp_valid", 64'(rd_rsp_valid), 64'(e_rv));
    if (e_rv) begin
      check("rd_rsp_tid", 64'(rd_rsp_tid), 64'(rq[0].tid));
      check("rd_rsp_data", rd_rsp_data, rq[0].data);
      void'(rq.pop_front());
    end
    if (!reset_n) begin
      check("reset_rsp_tid", 64'(rd_rsp_tid), 64'h0);
      check("reset_rsp_data", rd_rsp_data, 64'h0);
    end
    cyc++;
    mmio_rd_valid = 1'b0;
    mmio_wr_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step(0, 0, '0, 0, 0, '0);
  endtask

  typedef struct {
    int unsigned addr;
    bit          hit;
    logic [63:0] data;
  } vec_t;
  vec_t tbl[10];

  initial begin
    logic exp_v[7];
    for (int s = 0; s < NS * CPS; s++) pat[s] = mk_pat(s);
    reset_n = 1'b0;
    mmio_wr_valid = 1'b0; mmio_wr_addr = '0; mmio_wr_data = '0;
    mmio_rd_valid = 1'b0; mmio_rd_addr = '0; mmio_rd_tid = '0;

    tbl[0] = '{BASE + 0,  1'b1, 64'h2000_0000_0040_0001};
    tbl[1] = '{BASE + 16, 1'b1, 64'h2000_0000_0040_0002};
    tbl[2] = '{BASE + 32, 1'b1, 64'h2000_0000_0040_0003};
    tbl[3] = '{BASE + 64, 1'b1, 64'h2000_0100_0000_0005};
    tbl[4] = '{BASE + 1,  1'b1, 64'h0};
    tbl[5] = '{BASE + 80, 1'b0, 64'h0};
    tbl[6] = '{BASE - 2,  1'b0, 64'h0};
    tbl[7] = '{BASE + 79, 1'b1, 64'h0};
    tbl[8] = '{BASE + 2,  1'b1, 64'h0};
    tbl[9] = '{BASE + 58, 1'b1, mk_pat(29)};

    idle(2);                 // reset: all outputs zero
    reset_n = 1'b1;
    idle(1);

    // Table: single reads, response checked two cycles later.
    for (int unsigned i = 0; i < 10; i++) begin
      step(1, tbl[i].addr, 9'(i + 16), 0, 0, '0);
      step(0, 0, '0, 0, 0, '0);
      check("tbl_rsp_valid", 64'(rd_rsp_valid), 64'(tbl[i].hit));
      if (tbl[i].hit) begin
        check("tbl_rsp_tid", 64'(rd_rsp_tid), 64'(i + 16));
        check("tbl_rsp_data", rd_rsp_data, tbl[i].data);
      end
    end
    idle(1);

    // VTP mode register.
    step(0, 0, '0, 1, BASE + 2, 64'h3);
    check("vtp_en_set", 64'(vtp_enabled), 64'h1);
    check("vtp_pulse_set", 64'(vtp_inval_pulse), 64'h1);
    step(0, 0, '0, 0, 0, '0);
    check("vtp_pulse_clear", 64'(vtp_inval_pulse), 64'h0);
    step(1, BASE + 2, 9'h7, 0, 0, '0);
    step(0, 0, '0, 0, 0, '0);
    check("vtp_readback", rd_rsp_data, 64'h1);
    step(0, 0, '0, 1, BASE + 2, 64'h0);
    check("vtp_en_clr", 64'(vtp_enabled), 64'h0);
    check("vtp_no_pulse", 64'(vtp_inval_pulse), 64'h0);
    step(0, 0, '0, 1, BASE + 2, 64'h2);
    check("vtp_b2b_pulse0", 64'(vtp_inval_pulse), 64'h1);
    step(0, 0, '0, 1, BASE + 2, 64'h2);
    check("vtp_b2b_pulse1", 64'(vtp_inval_pulse), 64'h1);
    // Same-cycle read and write of the VTP CSR: read sees old value.
    step(1, BASE + 2, 9'h9, 1, BASE + 2, 64'h1);
    step(0, 0, '0, 0, 0, '0);
    check("rw_same_pre", rd_rsp_data, 64'h0);
    check("rw_same_en", 64'(vtp_enabled), 64'h1);

    // Shim write forwarding and dropped writes.
    step(0, 0, '0, 1, BASE + 58, 64'hDEAD_BEEF);
    check("fwd_valid", 64'(shim_wr_valid), 64'b01000);
    check("fwd_idx", 64'(shim_wr_idx), 64'd5);
    check("fwd_data", shim_wr_data, 64'hDEAD_BEEF);
    step(0, 0, '0, 0, 0, '0);
    check("fwd_one_cycle", 64'(shim_wr_valid), 64'h0);
    step(0, 0, '0, 1, BASE + 16, 64'h1234);
    check("drop_dfh", 64'(shim_wr_valid), 64'h0);
    step(0, 0, '0, 1, BASE + 3, 64'h1234);
    check("drop_misaligned", 64'(shim_wr_valid), 64'h0);
    step(0, 0, '0, 1, BASE - 2, 64'h1234);
    check("drop_below_window", 64'(shim_wr_valid), 64'h0);

    // Back-to-back reads with an out-of-window read interleaved.
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    step(1, BASE + 34, 9'd1, 0, 0, '0);
    check("pipe_v0", 64'(rd_rsp_valid), 64'(exp_v[0]));
    step(1, BASE + 36, 9'd2, 0, 0, '0);
    check("pipe_v1", 64'(rd_rsp_valid), 64'(exp_v[1]));
    step(1, BASE + 96, 9'h1FF, 0, 0, '0);
    check("pipe_v2", 64'(rd_rsp_valid), 64'(exp_v[2]));
    step(1, BASE + 38, 9'd3, 0, 0, '0);
    check("pipe_v3", 64'(rd_rsp_valid), 64'(exp_v[3]));
    step(1, BASE + 40, 9'd4, 0, 0, '0);
    check("pipe_v4", 64'(rd_rsp_valid), 64'(exp_v[4]));
    step(0, 0, '0, 0, 0, '0);
    check("pipe_v5", 64'(rd_rsp_valid), 64'(exp_v[5]));
    check("pipe_last_tid", 64'(rd_rsp_tid), 64'd4);
    check("pipe_last_data", rd_rsp_data, mk_pat(20));
    step(0, 0, '0, 0, 0, '0);
    check("pipe_v6", 64'(rd_rsp_valid), 64'(exp_v[6]));

    // Reset with reads in flight.
    step(0, 0, '0, 1, BASE + 2, 64'h1);
    step(1, BASE, 9'h11, 0, 0, '0);
    reset_n = 1'b0;
    step(1, BASE + 16, 9'h12, 0, 0, '0);
    step(0, 0, '0, 0, 0, '0);
    reset_n = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      step(0, 0, '0, 0, 0, '0);
      check("rst_no_rsp", 64'(rd_rsp_valid), 64'h0);
    end
    check("rst_vtp", 64'(vtp_enabled), 64'h0);
    step(1, BASE + 64, 9'h33, 0, 0, '0);
    check("post_rst_lat1", 64'(rd_rsp_valid), 64'h0);
    step(0, 0, '0, 0, 0, '0);
    check("post_rst_valid", 64'(rd_rsp_valid), 64'h1);
    check("post_rst_tid", 64'(rd_rsp_tid), 64'h33);
    check("post_rst_data", rd_rsp_data, 64'h2000_0100_0000_0005);
    idle(2);

    // Randomized traffic against the model.
    for (int s = 0; s < NS * CPS; s++) pat[s] = {$urandom, $urandom};
    for (int unsigned k = 0; k < 600; k++) begin
      int unsigned ra, wa;
      ra = BASE - 4 + $urandom_range(0, WIN + 7);
      wa = ($urandom_range(0, 3) == 0) ? BASE + 2 : BASE - 4 + $urandom_range(0, WIN + 7);
      reset_n = ($urandom_range(0, 63) != 0);
      step($urandom_range(0, 1) == 1, ra, 9'($urandom),
           $urandom_range(0, 1) == 1, wa, {$urandom, $urandom});
    end
    reset_n = 1'b1;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
